// File: rtl/cache_pkg.sv
// Shared types and width helpers for the direct-mapped write-through cache.
package cache_pkg;

   typedef enum logic [1:0] {
      C_IDLE  = 2'd0,
      C_FILL  = 2'd1,
      C_WRITE = 2'd2
   } state_t;

   function automatic int index_w(input int lines);
      return $clog2(lines);
   endfunction

   function automatic int tag_w(input int addr_w, input int lines);
      return addr_w - $clog2(lines);
   endfunction

endpackage

// File: rtl/cache_array.sv
// Valid/tag/data storage: one combinational read port, one write port, bulk valid clear.
module cache_array
   import cache_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LINES  = 16,
   localparam int INDEX_W = index_w(LINES),
   localparam int TAG_W   = tag_w(ADDR_W, LINES)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic [INDEX_W-1:0] rd_idx,
   output logic               rd_valid,
   output logic [TAG_W-1:0]   rd_tag,
   output logic [DATA_W-1:0]  rd_data,
   input  logic               we,
   input  logic [INDEX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [DATA_W-1:0]  wr_data
);

   logic [LINES-1:0]  valid;
   logic [TAG_W-1:0]  tags  [LINES];
   logic [DATA_W-1:0] words [LINES];

   // Only valid bits carry reset state; tag/data are meaningless while invalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
      end else if (clr) begin
         valid <= '0;
      end else if (we) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         tags[wr_idx]  <= wr_tag;
         words[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_idx];
   assign rd_tag   = tags[rd_idx];
   assign rd_data  = words[rd_idx];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-through cache controller: hit/miss lookup, fill and
// write-through FSM against a req/ack memory port, saturating statistics.
module cache_ctrl
   import cache_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LINES  = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data,
   input  logic              inv,
   output logic [DATA_W-1:0] q,
   output logic              ready,
   output logic              hit,
   output logic              busy,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int INDEX_W = index_w(LINES);
   localparam int TAG_W   = tag_w(ADDR_W, LINES);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   state_t              state, nxt;
   logic                rd_valid;
   logic [TAG_W-1:0]    rd_tag;
   logic [DATA_W-1:0]   rd_data;
   logic                lookup_hit;
   logic                arr_we, arr_clr;
   logic [INDEX_W-1:0]  arr_idx;
   logic [TAG_W-1:0]    arr_tag;
   logic [DATA_W-1:0]   arr_wdata;
   logic                start;
   logic                done, done_hit;
   logic [DATA_W-1:0]   done_q;
   logic                wr_hit;

   cache_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .LINES  (LINES)
   ) u_array (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (arr_clr),
      .rd_idx   (addr[INDEX_W-1:0]),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .we       (arr_we),
      .wr_idx   (arr_idx),
      .wr_tag   (arr_tag),
      .wr_data  (arr_wdata)
   );

   assign lookup_hit = rd_valid && (rd_tag == addr[ADDR_W-1:INDEX_W]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= C_IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt       = state;
      arr_we    = 1'b0;
      arr_clr   = 1'b0;
      arr_idx   = addr[INDEX_W-1:0];
      arr_tag   = addr[ADDR_W-1:INDEX_W];
      arr_wdata = data;
      start     = 1'b0;
      done      = 1'b0;
      done_hit  = 1'b0;
      done_q    = q;
      case (state)
         C_IDLE: begin
            // Invalidate takes priority; a coincident request is dropped.
            if (inv) begin
               arr_clr = 1'b1;
            end else if (req) begin
               if (wr) begin
                  arr_we = 1'b1;
                  start  = 1'b1;
                  nxt    = C_WRITE;
               end else if (!lookup_hit) begin
                  start = 1'b1;
                  nxt   = C_FILL;
               end else begin
                  done     = 1'b1;
                  done_hit = 1'b1;
                  done_q   = rd_data;
               end
            end
         end
         C_FILL: begin
            if (mem_ack) begin
               arr_we    = 1'b1;
               arr_idx   = mem_addr[INDEX_W-1:0];
               arr_tag   = mem_addr[ADDR_W-1:INDEX_W];
               arr_wdata = mem_rdata;
               done      = 1'b1;
               done_q    = mem_rdata;
               nxt       = C_IDLE;
            end
         end
         C_WRITE: begin
            if (mem_ack) begin
               done     = 1'b1;
               done_hit = wr_hit;
               nxt      = C_IDLE;
            end
         end
         default: nxt = C_IDLE;
      endcase
   end

   // Registered outputs, memory port latches and statistics.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q         <= '0;
         ready     <= 1'b0;
         hit       <= 1'b0;
         busy      <= 1'b0;
         mem_req   <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         wr_hit    <= 1'b0;
         hit_cnt   <= '0;
         miss_cnt  <= '0;
      end else begin
         ready <= done;
         busy  <= (nxt != C_IDLE);
         if (done) begin
            hit <= done_hit;
            q   <= done_q;
            if (done_hit) hit_cnt  <= sat_inc(hit_cnt);
            else          miss_cnt <= sat_inc(miss_cnt);
         end
         if (start) begin
            mem_req  <= 1'b1;
            mem_wr   <= wr;
            mem_addr <= addr;
            wr_hit   <= lookup_hit;
            if (wr) mem_wdata <= data;
         end else if (done && state != C_IDLE) begin
            mem_req <= 1'b0;
            mem_wr  <= 1'b0;
         end
      end
   end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Parametrised direct-mapped, write-through cache controller between a processor-side single-word request port and a slower memory port with a req/ack handshake. Next generation of the team's fixed-size cache: configurable address/data width and line count, valid bits, real miss handling with stalls, an invalidate-all command and hit/miss statistics. One word per line, word-addressed.

## Interface
- ADDR_W, 32, word-address width
- DATA_W, 32, data word width
- LINES, 16, number of lines; power of two, ≥2; INDEX_W = log2(LINES), TAG_W = ADDR_W − INDEX_W
- CNT_W, 16, width of the hit/miss counters
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  single-cycle request strobe, legal only while busy=0
- wr  in  1  1 = write, 0 = read; qualified by req
- addr  in  ADDR_W  request address
- data  in  DATA_W  write data
- inv  in  1  invalidate all lines; honoured only while busy=0
- q  out  DATA_W  read data, valid when ready=1
- ready  out  1  one-cycle completion pulse
- hit  out  1  hit/miss flag of the completing request, valid when ready=1
- busy  out  1  registered, high in every state except IDLE
- mem_req, mem_wr  out  1 each  memory request, direction
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W
- mem_rdata  in  DATA_W; mem_ack  in  1  memory completion, one cycle
- hit_cnt, miss_cnt  out  CNT_W each  saturating statistics

## Operation
- Storage per line: valid, tag[TAG_W], word[DATA_W]; index = addr[INDEX_W-1:0], tag = addr[ADDR_W-1:INDEX_W]. Hit = valid & tag match.
- States: IDLE, FILL, WRITE.
- IDLE, req, read hit: next cycle ready=1, hit=1, q=line word; stay IDLE; no memory traffic.
- IDLE, req, read miss: latch addr; → FILL. FILL: mem_req=1, mem_wr=0, mem_addr=latched addr until mem_ack. On ack cycle write line (valid=1, tag, mem_rdata); next cycle ready=1, hit=0, q=mem_rdata; → IDLE.
- IDLE, req, write (hit or miss): line written immediately (write-allocate: valid=1, tag, data); latch addr/data; → WRITE. WRITE: mem_req=1, mem_wr=1, mem_wdata=data until mem_ack; next cycle ready=1, hit=pre-write hit status; → IDLE. q unchanged by writes.
- inv in IDLE: all valid bits cleared in one edge. inv and req in same cycle: inv wins, req dropped, no ready.
- Counters: +1 hit_cnt or miss_cnt on each ready pulse per hit flag; saturate at 2^CNT_W−1; cleared only by reset.
- req while busy=1 and mem_ack outside FILL/WRITE: ignored.

## Timing
- Reset values: q=0, ready=0, hit=0, busy=0, mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0, hit_cnt=0, miss_cnt=0, all valid=0, state IDLE.
- Read-hit latency 1 cycle (req edge → ready). Miss/write latency = memory ack latency + 2.
- mem_req, mem_wr, mem_addr, mem_wdata registered, stable from first request cycle through ack cycle; mem_req low the cycle after ack. Ack in the first mem_req cycle is legal.
- busy rises the cycle after an accepting req on miss/write, falls together with ready.
- Reset mid-transaction: all outputs to reset values asynchronously, transaction abandoned, no ready, line contents invalid.

## Structure
- Package cache_pkg: state enum (C_IDLE, C_FILL, C_WRITE), index/tag width helper functions.
- Sub-module cache_array: valid/tag/data storage, one combinational read port, one write port, single-cycle clear-all of valid bits, reset clears valid. Controller FSM, latches and counters live in cache_ctrl.

## Test plan
- Reset, read 0x04 → mem_req, mem_addr=0x04; ack with 0xDEADBEEF after 3 cycles → ready, q=0xDEADBEEF, hit=0; read 0x04 again → ready next cycle, hit=1, no mem_req.
- Write 0x00 data 0x1 → mem_wr=1, mem_wdata=0x1; ack → ready; read 0x00 → hit=1, q=0x1 with no memory access.
- Conflict (LINES=16): read 0x03, read 0x13, read 0x03 → three misses, miss_cnt=3.
- Fill 0x04, pulse inv → read 0x04 misses; inv and req same cycle → no ready, no mem_req, busy stays 0.
- Assert rst_n=0 during FILL before ack → mem_req=0 and busy=0 immediately; after release, read of earlier-filled line misses.
- CNT_W=2: five read hits → hit_cnt=3 holds; miss_cnt unchanged.
